// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: active-low segment
// patterns {g,f,e,d,c,b,a} and digit position names.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   localparam logic [1:0] SEC_ONES = 2'd0;
   localparam logic [1:0] SEC_TENS = 2'd1;
   localparam logic [1:0] MIN_ONES = 2'd2;
   localparam logic [1:0] MIN_TENS = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low 7-segment pattern; non-BCD codes show a dash.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nib)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver with per-frame snapshot and
// adjust-mode blinking of one digit pair. All outputs are registered.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int DP_POS   = 2,
   parameter bit BLINK_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan_tick,
   input  logic        blink_tick,
   input  logic [15:0] digits,
   input  logic        adj_en,
   input  logic        adj_sel,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam bit         DP_ON  = (DP_POS >= 0) && (DP_POS < 4);
   localparam logic [1:0] DP_IDX = DP_ON ? DP_POS[1:0] : 2'd0;

   logic [1:0]  idx, idx_nx;
   logic        phase, phase_nx;
   logic [15:0] snap, snap_nx;
   logic        lit, lit_nx;
   logic        wrap, blank;
   logic [3:0]  nib;
   logic [6:0]  dseg;

   // The first tick after reset behaves like a frame wrap so the display
   // starts at digit 0 with a fresh snapshot rather than at digit 1.
   always_comb begin
      wrap     = scan_tick && (!lit || idx == MIN_TENS);
      idx_nx   = idx;
      if (scan_tick) idx_nx = wrap ? SEC_ONES : idx + 2'd1;
      snap_nx  = wrap ? digits : snap;
      lit_nx   = lit | scan_tick;
      phase_nx = adj_en ? (phase ^ blink_tick) : 1'b0;
      blank    = BLINK_EN && adj_en && phase_nx && (idx_nx[1] == adj_sel);
      nib      = 4'd0;
      case (idx_nx)
         SEC_ONES: nib = snap_nx[3:0];
         SEC_TENS: nib = snap_nx[7:4];
         MIN_ONES: nib = snap_nx[11:8];
         MIN_TENS: nib = snap_nx[15:12];
         default:  nib = 4'd0;
      endcase
   end

   seg7_decode u_dec (
      .nib (nib),
      .seg (dseg)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx   <= SEC_ONES;
         phase <= 1'b0;
         snap  <= 16'h0000;
         lit   <= 1'b0;
         an    <= 4'hF;
         seg   <= SEG_OFF;
         dp    <= 1'b1;
      end else begin
         idx   <= idx_nx;
         phase <= phase_nx;
         snap  <= snap_nx;
         lit   <= lit_nx;
         // Recomputed every cycle once running: snap and idx are stable
         // between ticks, so only blink state can actually change seg/dp.
         if (lit_nx) begin
            an  <= ~(4'b0001 << idx_nx);
            seg <= blank ? SEG_OFF : dseg;
            dp  <= !(DP_ON && (idx_nx == DP_IDX) && !blank);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: directed per-cycle stimulus pushes the
// expected registered outputs; a monitor pops and compares after each edge.
module tb_seg7_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scan_tick = 1'b0, blink_tick = 1'b0;
   logic [15:0] digits = 16'h0000;
   logic        adj_en = 1'b0, adj_sel = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   logic [15:0] nxt_digits = 16'h0000;
   logic        nxt_adj_en = 1'b0, nxt_adj_sel = 1'b0;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   step_id = 0;

   seg7_scan #(.DP_POS(2), .BLINK_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .scan_tick(scan_tick), .blink_tick(blink_tick),
      .digits(digits), .adj_en(adj_en), .adj_sel(adj_sel),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input exp_t e);
      n_cmp++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
         n_bad++;
         $display("FAIL %s step %0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                  name, e.id, an, seg, dp, e.an, e.seg, e.dp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and queue what the outputs
   // must be after the following rising edge.
   task automatic cyc(input logic s, input logic b,
                      input logic [3:0] ea, input logic [6:0] es, input logic ed);
      exp_t e;
      @(negedge clk);
      scan_tick  = s;
      blink_tick = b;
      digits     = nxt_digits;
      adj_en     = nxt_adj_en;
      adj_sel    = nxt_adj_sel;
      step_id++;
      e.an = ea; e.seg = es; e.dp = ed; e.id = step_id;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scan", e);
         end
      end
   end

   initial begin : stim
      exp_t e;
      // Reset state, held with the clock running
      cyc(0, 0, 4'hF, 7'h7F, 1'b1);
      cyc(0, 0, 4'hF, 7'h7F, 1'b1);
      @(negedge clk) rst = 1'b1;
      // Released, no ticks: stays dark
      cyc(0, 0, 4'hF, 7'h7F, 1'b1);
      cyc(0, 0, 4'hF, 7'h7F, 1'b1);
      // Full scan of 1259
      nxt_digits = 16'h1259;
      cyc(1, 0, 4'hE, 7'h10, 1'b1);
      cyc(0, 0, 4'hE, 7'h10, 1'b1);
      cyc(1, 0, 4'hD, 7'h12, 1'b1);
      cyc(1, 0, 4'hB, 7'h24, 1'b0);
      cyc(1, 0, 4'h7, 7'h79, 1'b1);
      // Snapshot: change digits mid-frame
      cyc(1, 0, 4'hE, 7'h10, 1'b1);
      cyc(1, 0, 4'hD, 7'h12, 1'b1);
      nxt_digits = 16'h0000;
      cyc(1, 0, 4'hB, 7'h24, 1'b0);
      cyc(1, 0, 4'h7, 7'h79, 1'b1);
      cyc(1, 0, 4'hE, 7'h40, 1'b1);
      cyc(1, 0, 4'hD, 7'h40, 1'b1);
      cyc(1, 0, 4'hB, 7'h40, 1'b0);
      cyc(1, 0, 4'h7, 7'h40, 1'b1);
      // Invalid BCD, loaded on the wrap tick (back-to-back ticks throughout)
      nxt_digits = 16'hA0F0;
      cyc(1, 0, 4'hE, 7'h40, 1'b1);
      cyc(1, 0, 4'hD, 7'h3F, 1'b1);
      cyc(1, 0, 4'hB, 7'h40, 1'b0);
      cyc(1, 0, 4'h7, 7'h3F, 1'b1);
      // Blink minutes pair
      nxt_adj_en = 1'b1; nxt_adj_sel = 1'b1;
      cyc(1, 0, 4'hE, 7'h40, 1'b1);
      cyc(0, 1, 4'hE, 7'h40, 1'b1);
      cyc(1, 0, 4'hD, 7'h3F, 1'b1);
      cyc(1, 0, 4'hB, 7'h7F, 1'b1);
      cyc(1, 0, 4'h7, 7'h7F, 1'b1);
      cyc(0, 1, 4'h7, 7'h3F, 1'b1);
      cyc(0, 1, 4'h7, 7'h7F, 1'b1);
      nxt_adj_en = 1'b0;
      cyc(0, 0, 4'h7, 7'h3F, 1'b1);
      // Coincident scan and blink entering digit 2
      nxt_adj_en = 1'b1;
      cyc(1, 0, 4'hE, 7'h40, 1'b1);
      cyc(1, 0, 4'hD, 7'h3F, 1'b1);
      cyc(1, 1, 4'hB, 7'h7F, 1'b1);
      nxt_adj_sel = 1'b0;
      cyc(0, 0, 4'hB, 7'h40, 1'b0);
      // Async reset between edges
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.id = -1;
      check("async_rst", e);
      @(negedge clk) rst = 1'b1;
      // Fresh frame starts at digit 0 with a new snapshot
      nxt_digits = 16'h1259;
      cyc(1, 0, 4'hE, 7'h10, 1'b1);
      cyc(1, 0, 4'hD, 7'h12, 1'b1);
      cyc(0, 0, 4'hD, 7'h12, 1'b1);
      // Drain the scoreboard, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
